scalar_reg_bank: RTL and testbench

- Eight-entry scalar register bank that sits directly upstream of the scalar 8:1 select stage.
- Exposes all eight registers in parallel as R00..R07, which feed the select stage's D00..D07 inputs.
- Accepts write-back results through a 2-entry valid/ready commit queue.
- Tracks per-register pending-write (busy) bits for the issue stage so it can detect read-after-write hazards.

---
 rtl/scalar_reg_bank.sv | 106 ++++++++++
 tb/tb_scalar_reg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_reg_bank.sv
// Eight-entry scalar register bank with a 2-deep write-back commit queue
// and a per-register busy scoreboard for read-after-write hazard detection.
module scalar_reg_bank #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_valid,
  output logic         wb_ready,
  input  logic [3:0]   wb_addr,
  input  logic [N-1:0] wb_data,
  input  logic         commit_stall,
  input  logic         iss_valid,
  input  logic [3:0]   iss_addr,
  output logic [7:0]   busy,
  output logic         err,
  output logic [1:0]   q_count,
  output logic [N-1:0] R00,
  output logic [N-1:0] R01,
  output logic [N-1:0] R02,
  output logic [N-1:0] R03,
  output logic [N-1:0] R04,
  output logic [N-1:0] R05,
  output logic [N-1:0] R06,
  output logic [N-1:0] R07
);

  logic [N-1:0] r_regs  [8];
  logic [2:0]   r_qAddr [2];
  logic [N-1:0] r_qData [2];
  logic         r_head;
  logic [1:0]   r_count;
  logic [7:0]   r_busy;
  logic         r_err;

  logic         w_accept;
  logic         w_wbBad;
  logic         w_issBad;
  logic         w_push;
  logic         w_pop;
  logic         w_tail;
  logic [7:0]   w_busyNext;

  assign wb_ready = (r_count != 2'd2);
  assign w_accept = wb_valid && wb_ready;
  assign w_wbBad  = w_accept && wb_addr[3];
  assign w_issBad = iss_valid && iss_addr[3];
  assign w_push   = w_accept && !wb_addr[3];
  assign w_pop    = (r_count != 2'd0) && !commit_stall;
  // With one entry queued the free slot is the one after the head.
  assign w_tail   = r_head ^ r_count[0];

  // Clear on commit first, then set on issue so a newer producer wins.
  always_comb begin
    w_busyNext = r_busy;
    if (w_pop)
      w_busyNext[r_qAddr[r_head]] = 1'b0;
    if (iss_valid && !iss_addr[3])
      w_busyNext[iss_addr[2:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        r_regs[i] <= '0;
      for (int j = 0; j < 2; j++) begin
        r_qAddr[j] <= '0;
        r_qData[j] <= '0;
      end
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_busy  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_qAddr[w_tail] <= wb_addr[2:0];
        r_qData[w_tail] <= wb_data;
      end
      if (w_pop) begin
        r_regs[r_qAddr[r_head]] <= r_qData[r_head];
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_busy <= w_busyNext;
      r_err  <= w_wbBad || w_issBad;
    end
  end

  assign busy    = r_busy;
  assign err     = r_err;
  assign q_count = r_count;

  assign R00 = r_regs[0];
  assign R01 = r_regs[1];
  assign R02 = r_regs[2];
  assign R03 = r_regs[3];
  assign R04 = r_regs[4];
  assign R05 = r_regs[5];
  assign R06 = r_regs[6];
  assign R07 = r_regs[7];

endmodule

// File: tb/tb_scalar_reg_bank.sv
// Directed self-checking bench for scalar_reg_bank: reset, commit latency,
// busy scoreboard, queue backpressure, error pulses and reset flush.
module tb_scalar_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbAddr;
  logic [3:0]  wbData;
  logic        commitStall;
  logic        issValid;
  logic [3:0]  issAddr;
  logic [7:0]  busy;
  logic        err;
  logic [1:0]  qCount;
  logic [3:0]  r0, r1, r2, r3, r4, r5, r6, r7;
  logic [31:0] allRegs;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  assign allRegs = {r7, r6, r5, r4, r3, r2, r1, r0};

  scalar_reg_bank #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wbValid), .wb_ready(wbReady), .wb_addr(wbAddr), .wb_data(wbData),
    .commit_stall(commitStall), .iss_valid(issValid), .iss_addr(issAddr),
    .busy(busy), .err(err), .q_count(qCount),
    .R00(r0), .R01(r1), .R02(r2), .R03(r3),
    .R04(r4), .R05(r5), .R06(r6), .R07(r7)
  );

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wbValid = 1'b0; wbAddr = 4'd0; wbData = 4'd0;
    commitStall = 1'b0; issValid = 1'b0; issAddr = 4'd0;
    step();
    step();
    rst = 1'b0;
    testCount++;
    if (allRegs !== 32'h0) begin
      $display("[TB] FAIL reset_regs got %h want %h", allRegs, 32'h0); failCount++;
    end
    testCount++;
    if (busy !== 8'h00 || qCount !== 2'd0 || err !== 1'b0 || wbReady !== 1'b1) begin
      $display("[TB] FAIL reset_ctrl got busy=%h q=%0d err=%b rdy=%b want 00/0/0/1",
               busy, qCount, err, wbReady); failCount++;
    end
  endtask

  task automatic test_commit_latency();
    wbValid = 1'b1; wbAddr = 4'd3; wbData = 4'hA;
    step();
    wbValid = 1'b0;
    testCount++;
    if (qCount !== 2'd1 || r3 !== 4'h0) begin
      $display("[TB] FAIL latency_push got q=%0d R03=%h want 1/0", qCount, r3); failCount++;
    end
    step();
    testCount++;
    if (qCount !== 2'd0 || allRegs !== 32'h0000_A000) begin
      $display("[TB] FAIL latency_commit got q=%0d regs=%h want 0/0000a000", qCount, allRegs);
      failCount++;
    end
  endtask

  task automatic test_busy();
    issValid = 1'b1; issAddr = 4'd5;
    step();
    issValid = 1'b0;
    wbValid = 1'b1; wbAddr = 4'd5; wbData = 4'h7;
    testCount++;
    if (busy !== 8'b0010_0000) begin
      $display("[TB] FAIL busy_set got %b want 00100000", busy); failCount++;
    end
    step();
    wbValid = 1'b0;
    testCount++;
    if (busy !== 8'b0010_0000 || r5 !== 4'h0) begin
      $display("[TB] FAIL busy_hold got busy=%b R05=%h want 00100000/0", busy, r5); failCount++;
    end
    step();
    testCount++;
    if (busy !== 8'h00 || r5 !== 4'h7) begin
      $display("[TB] FAIL busy_clear got busy=%b R05=%h want 00000000/7", busy, r5); failCount++;
    end
  endtask

  task automatic test_back_to_back();
    commitStall = 1'b1;
    wbValid = 1'b1; wbAddr = 4'd1; wbData = 4'h1;
    step();
    wbAddr = 4'd2; wbData = 4'h2;
    step();
    testCount++;
    if (qCount !== 2'd2 || wbReady !== 1'b0) begin
      $display("[TB] FAIL full got q=%0d rdy=%b want 2/0", qCount, wbReady); failCount++;
    end
    wbAddr = 4'd6; wbData = 4'h3;
    step();
    testCount++;
    if (qCount !== 2'd2 || wbReady !== 1'b0 || r1 !== 4'h0) begin
      $display("[TB] FAIL held got q=%0d rdy=%b R01=%h want 2/0/0", qCount, wbReady, r1);
      failCount++;
    end
    commitStall = 1'b0;
    step();
    testCount++;
    if (r1 !== 4'h1 || r2 !== 4'h0 || qCount !== 2'd1 || wbReady !== 1'b1) begin
      $display("[TB] FAIL drain1 got R01=%h R02=%h q=%0d rdy=%b want 1/0/1/1",
               r1, r2, qCount, wbReady); failCount++;
    end
    step();
    wbValid = 1'b0;
    testCount++;
    if (r2 !== 4'h2 || r6 !== 4'h0 || qCount !== 2'd1) begin
      $display("[TB] FAIL drain2 got R02=%h R06=%h q=%0d want 2/0/1", r2, r6, qCount);
      failCount++;
    end
    step();
    testCount++;
    if (r6 !== 4'h3 || qCount !== 2'd0) begin
      $display("[TB] FAIL drain3 got R06=%h q=%0d want 3/0", r6, qCount); failCount++;
    end
  endtask

  task automatic test_set_wins();
    wbValid = 1'b1; wbAddr = 4'd4; wbData = 4'h9;
    step();
    wbValid = 1'b0;
    issValid = 1'b1; issAddr = 4'd4;
    step();
    issValid = 1'b0;
    testCount++;
    if (r4 !== 4'h9 || busy !== 8'b0001_0000) begin
      $display("[TB] FAIL set_wins got R04=%h busy=%b want 9/00010000", r4, busy); failCount++;
    end
  endtask

  task automatic test_error();
    wbValid = 1'b1; wbAddr = 4'd9; wbData = 4'hF;
    step();
    wbValid = 1'b0;
    testCount++;
    if (err !== 1'b1 || qCount !== 2'd0 || wbReady !== 1'b1) begin
      $display("[TB] FAIL err_wb got err=%b q=%0d rdy=%b want 1/0/1", err, qCount, wbReady);
      failCount++;
    end
    step();
    testCount++;
    if (err !== 1'b0 || allRegs !== 32'h0379_A210 || busy !== 8'b0001_0000) begin
      $display("[TB] FAIL err_wb_clean got err=%b regs=%h busy=%b want 0/0379a210/00010000",
               err, allRegs, busy); failCount++;
    end
    issValid = 1'b1; issAddr = 4'd12;
    step();
    issValid = 1'b0;
    testCount++;
    if (err !== 1'b1 || busy !== 8'b0001_0000) begin
      $display("[TB] FAIL err_iss got err=%b busy=%b want 1/00010000", err, busy); failCount++;
    end
    step();
    testCount++;
    if (err !== 1'b0 || busy !== 8'b0001_0000 || allRegs !== 32'h0379_A210) begin
      $display("[TB] FAIL err_iss_clean got err=%b busy=%b regs=%h want 0/00010000/0379a210",
               err, busy, allRegs); failCount++;
    end
  endtask

  task automatic test_reset_flush();
    commitStall = 1'b1;
    wbValid = 1'b1; wbAddr = 4'd0; wbData = 4'hE;
    issValid = 1'b1; issAddr = 4'd0;
    step();
    wbAddr = 4'd7; wbData = 4'hD; issAddr = 4'd7;
    step();
    wbValid = 1'b0; issValid = 1'b0;
    testCount++;
    if (qCount !== 2'd2 || busy !== 8'b1001_0001) begin
      $display("[TB] FAIL pre_flush got q=%0d busy=%b want 2/10010001", qCount, busy);
      failCount++;
    end
    rst = 1'b1; commitStall = 1'b0;
    step();
    rst = 1'b0;
    testCount++;
    if (allRegs !== 32'h0 || busy !== 8'h00 || qCount !== 2'd0 || wbReady !== 1'b1) begin
      $display("[TB] FAIL flush got regs=%h busy=%b q=%0d rdy=%b want 0/0/0/1",
               allRegs, busy, qCount, wbReady); failCount++;
    end
    step();
    step();
    testCount++;
    if (allRegs !== 32'h0 || qCount !== 2'd0 || err !== 1'b0) begin
      $display("[TB] FAIL no_stale got regs=%h q=%0d err=%b want 0/0/0", allRegs, qCount, err);
      failCount++;
    end
  endtask

  initial begin
    test_reset();
    test_commit_latency();
    test_busy();
    test_back_to_back();
    test_set_wins();
    test_error();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
